// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_pkg
// Brief    : Shared types and constants for the instruction-ROM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

  // APB slave handshake states
  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_WAIT = 2'd1,
    A_DONE = 2'd2
  } apb_state_e;

  // Performance counter addresses, only decoded when the perf build is enabled
  localparam logic [11:0] PERF_FGNT_ADDR  = 12'hF00;
  localparam logic [11:0] PERF_AWAIT_ADDR = 12'hF04;

  // addi x0,x0,0
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/rom_arb_apb_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_apb_fsm
// Brief    : APB slave handshake for the ROM arbiter. Tracks setup/wait/done,
//            captures read data and error when the arbiter grants APB, and
//            holds the response until the next capture.
// Revision : 1.0 - initial release
// ============================================================================
module rom_arb_apb_fsm
  import rom_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        apb_win,
  input  logic [31:0] rd_data,
  input  logic        rd_err,
  output apb_state_e  state,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  apb_state_e  r_state;
  apb_state_e  w_next;
  logic [31:0] r_prdata;
  logic        r_pslverr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= A_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: setup opens a transfer, a grant completes it, dropping PSEL abandons it
  always_comb begin
    w_next = r_state;
    case (r_state)
      A_IDLE: if (psel && !penable) w_next = A_WAIT;
      A_WAIT: begin
        if (!psel)        w_next = A_IDLE;
        else if (apb_win) w_next = A_DONE;
      end
      A_DONE:  w_next = A_IDLE;
      default: w_next = A_IDLE;
    endcase
  end

  // Response capture on the granted wait cycle; held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else if (apb_win) begin
      r_prdata  <= rd_data;
      r_pslverr <= rd_err;
    end
  end

  assign state   = r_state;
  assign pready  = (r_state == A_DONE);
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Brief    : Shares a single-read-port instruction ROM between the fetch path
//            (fixed priority) and an APB debug/readback port. A starvation
//            counter forces an APB grant after STARVE_MAX consecutive fetch
//            wins. Read data is registered: one cycle latency for both sides.
//            Optional build macro ROM_ARB_PERF_EN adds fetch-grant and
//            APB-wait performance counters at 0xF00 / 0xF04.
// Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int          ROM_DEPTH  = 62,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] NOP_INSTR  = RV32I_NOP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_fault,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [11:0] PADDR,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [31:0]      ROM_BYTES  = 32'(ROM_DEPTH * 4);
  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  apb_state_e       w_apb_state;
  logic             w_apb_req;
  logic             w_apb_win;
  logic             w_f_win;
  logic             w_f_oor;
  logic [31:0]      w_apb_addr;
  logic [31:0]      w_apb_rdata;
  logic             w_apb_err;
  logic [CNT_W-1:0] r_starve;
  logic             r_f_rvalid;
  logic [31:0]      r_f_rdata;
  logic             r_f_fault;

  assign w_apb_addr = {20'b0, PADDR};
  assign w_apb_req  = PSEL & PENABLE & (w_apb_state == A_WAIT);
  assign w_apb_win  = w_apb_req & (!f_req | (r_starve == STARVE_LIM));
  // Gated with reset so no grant is advertised while the block is held in reset
  assign w_f_win    = reset_n & f_req & !w_apb_win;
  assign w_f_oor    = (f_addr >= ROM_BYTES);

  assign f_gnt    = w_f_win;
  assign rom_addr = w_apb_win ? w_apb_addr : (w_f_win ? f_addr : 32'b0);

  // Fetch response: one-cycle valid pulse per accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_f_fault  <= 1'b0;
    end else begin
      r_f_rvalid <= w_f_win;
      if (w_f_win) begin
        r_f_rdata <= w_f_oor ? NOP_INSTR : rom_data;
        r_f_fault <= w_f_oor;
      end
    end
  end

  assign f_rvalid = r_f_rvalid;
  assign f_rdata  = r_f_rdata;
  assign f_fault  = r_f_fault;

  // Starvation counter: counts fetch wins while APB is waiting, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_starve <= '0;
    else if (w_f_win && w_apb_req) begin
      if (r_starve != STARVE_LIM) r_starve <= r_starve + 1'b1;
    end else                      r_starve <= '0;
  end

`ifdef ROM_ARB_PERF_EN
  logic [31:0] r_perf_fgnt;
  logic [31:0] r_perf_await;

  // Wrapping performance counters: fetch grants and cycles spent in A_WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fgnt  <= '0;
      r_perf_await <= '0;
    end else begin
      if (w_f_win)                 r_perf_fgnt  <= r_perf_fgnt + 32'd1;
      if (w_apb_state == A_WAIT)   r_perf_await <= r_perf_await + 32'd1;
    end
  end
`endif

  // APB address decode: ROM window, optional perf registers, error elsewhere
  always_comb begin
    w_apb_rdata = '0;
    w_apb_err   = 1'b1;
    if (w_apb_addr < ROM_BYTES) begin
      w_apb_rdata = rom_data;
      w_apb_err   = 1'b0;
    end
`ifdef ROM_ARB_PERF_EN
    else if (PADDR == PERF_FGNT_ADDR) begin
      w_apb_rdata = r_perf_fgnt;
      w_apb_err   = 1'b0;
    end else if (PADDR == PERF_AWAIT_ADDR) begin
      w_apb_rdata = r_perf_await;
      w_apb_err   = 1'b0;
    end
`endif
  end

  rom_arb_apb_fsm u_apb_fsm (
    .clk     (clk),
    .rst_n   (reset_n),
    .psel    (PSEL),
    .penable (PENABLE),
    .apb_win (w_apb_win),
    .rd_data (w_apb_rdata),
    .rd_err  (w_apb_err),
    .state   (w_apb_state),
    .pready  (PREADY),
    .prdata  (PRDATA),
    .pslverr (PSLVERR)
  );

endmodule
`default_nettype wire
